dcache_assoc_wb: RTL and testbench
==================================

Name: dcache_assoc_wb

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache between the pipeline MEM stage and the line-wide data memory. It supersedes the direct-mapped cache with these changes:
- fully clocked FSM;
- configurable ways, sets and line width;
- LRU replacement;
- line-aligned memory addressing;
- a flush command that writes back all dirty lines.

Hits complete with no stall. Misses stall the pipeline through `mem_stall_o` until the refill finishes.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_W, 256, line width in bits; power of two, at least 64.
- SETS, 16, number of sets; power of two.
- WAYS, 2, associativity; one of 1, 2 or 4.
- Derived: OFF = log2(LINE_W/8); IDX = log2(SETS); TAG = ADDR_W-IDX-OFF; word select = address_i[OFF-1:2].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- address_i  in  ADDR_W  byte address; word-aligned.
- write_data_i  in  32  store data.
- MemRead_i  in  1  load request.
- MemWrite_i  in  1  store request.
- flush_i  in  1  request write-back of all dirty lines.
- read_data_o  out  32  load data.
- mem_stall_o  out  1  pipeline stall.
- flush_done_o  out  1  one-cycle pulse when a flush completes.
- mem_data_i  in  LINE_W  refill data from memory.
- mem_ack_i  in  1  one-cycle memory completion pulse.
- mem_data_o  out  LINE_W  write-back data to memory.
- mem_addr_o  out  ADDR_W  line address to memory; low OFF bits always 0.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  memory write (1) or read (0).

Behaviour:
- **Reset (rst_i=0, async):**
  - All valid, dirty and LRU state cleared; FSM to IDLE.
  - mem_enable_o, mem_write_o, mem_stall_o, flush_done_o = 0.
  - mem_addr_o = 0, mem_data_o = 0, read_data_o = 0.
  - Any memory transaction in flight is abandoned; a late mem_ack_i is ignored in IDLE.
- **Lookup (combinational):** hit when any way in set address_i[OFF+IDX-1:OFF] is valid with a matching tag. WAYS=1 behaves as direct-mapped.
- **Read hit:** read_data_o = selected word of the hit way, same cycle; mem_stall_o = 0.
- **Write hit:** word written and dirty set at the next clk_i edge; no stall.
- **LRU update:** on every hit, at the clock edge, the hit way becomes MRU.
- **Priority:** MemRead_i and MemWrite_i together are treated as a write.
- **Miss:** mem_stall_o = 1 combinationally in the same cycle.
  - Victim = lowest-index invalid way; otherwise the LRU way.
- **FSM states:** IDLE, WB, REFILL, DONE, FL_SCAN, FL_WB.
- **IDLE →**
  - On a miss with a dirty victim: go to WB.
    - mem_enable_o=1, mem_write_o=1.
    - mem_addr_o = {victim tag, index, OFF'b0}.
    - mem_data_o = victim line.
  - On a miss with a clean victim: go to REFILL.
    - mem_enable_o=1, mem_write_o=0.
    - mem_addr_o = {address tag, index, OFF'b0}.
- **WB:** outputs held stable until mem_ack_i; then go to REFILL.
- **REFILL:** on mem_ack_i:
  - Victim way loaded from mem_data_i; valid=1, dirty=0, way becomes MRU.
  - mem_enable_o deasserts; go to DONE.
- **DONE:** one cycle; stall stays high. Return to IDLE, where the replayed access now hits.
  - Clean miss costs memory latency + 2 stall cycles.
  - Dirty miss adds one more memory transaction.
- **Memory handshake:**
  - mem_enable_o rises only from IDLE or FL_SCAN.
  - Address, data and write are held constant while enable is high.
  - mem_ack_i is ignored in IDLE, DONE and FL_SCAN.
- **Flush:** accepted only in IDLE with no access pending; an access in the same cycle is serviced first.
  - mem_stall_o = 1 throughout the flush.
  - FL_SCAN walks set 0..SETS-1, way 0..WAYS-1, one line per cycle.
  - A dirty line goes to FL_WB: write it back, clear dirty on ack (valid is kept), then resume the scan.
  - After the last line: flush_done_o pulses for one cycle, then return to IDLE.
  - Flush with no dirty lines takes SETS*WAYS+1 cycles.
- **Inputs during stall:** inputs are assumed held by the stalled pipeline. The cache latches address, data and operation at the miss and uses the latched copy until DONE.

Test Plan (defaults; index = addr[8:5]; tag step 0x200):
- Reset, then read 0x040 → stall; mem read at 0x040. Ack data with word0 = 0xDEADBEEF → after DONE, read_data_o = 0xDEADBEEF with no stall; a second read of 0x040 hits with 0 stall cycles.
- Write 0x1234 to 0x044, then read 0x240 and 0x440 (same set) → 0x240 fills way1. 0x440 evicts LRU way0 (dirty): mem write at 0x040 with word1 = 0x1234 precedes the mem read at 0x440.
- Read 0x040, 0x240, then read 0x040 (hit, updates LRU), then read 0x640 → victim is the 0x240 way; no write-back because it is clean.
- Store to 0x080 and 0x2A0, then pulse flush_i → exactly two mem writes (0x080, 0x2A0), flush_done_o pulses once, and a subsequent read of 0x080 hits with dirty=0.
- Drive rst_i low while in WB awaiting ack → outputs return to reset values; ack arriving afterwards is ignored; the next read of 0x040 misses.
- MemRead_i and MemWrite_i both high on a hit to 0x040 with data 0xA5A5A5A5 → treated as a write; a later read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/dcache_assoc_wb.sv
// rtl/dcache_assoc_wb.sv - N-way set-associative write-back, write-allocate data cache with LRU and flush
module dcache_assoc_wb #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [31:0]       write_data_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              flush_i,
  output logic [31:0]       read_data_o,
  output logic              mem_stall_o,
  output logic              flush_done_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int OFF  = $clog2(LINE_W / 8);
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = ADDR_W - IDX - OFF;
  localparam int WSEL = OFF - 2;
  localparam int WIW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW   = $clog2(SETS * WAYS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB      = 3'd1;
  localparam logic [2:0] S_REFILL  = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_FL_SCAN = 3'd4;
  localparam logic [2:0] S_FL_WB   = 3'd5;

  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [TAG-1:0]    tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  // Per-set age ranking: 0 is MRU, WAYS-1 is LRU; kept as a permutation.
  logic [WIW-1:0]    age_q   [SETS][WAYS];

  logic [2:0]        state_q, state_d;
  logic [IDX-1:0]    lat_idx_q, lat_idx_d;
  logic [TAG-1:0]    lat_tag_q, lat_tag_d;
  logic [WIW-1:0]    vic_q, vic_d;
  logic [CW-1:0]     scan_q, scan_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  logic              done_q, done_d;

  logic [IDX-1:0]    idx;
  logic [TAG-1:0]    tag;
  logic [WSEL-1:0]   wsel;
  logic              access, hit, vic_found, idle;
  logic [WIW-1:0]    hit_way, vic_way;
  logic [LINE_W-1:0] hit_line;
  logic [IDX-1:0]    scan_set;
  logic [WIW-1:0]    scan_way;
  logic              scan_last, scan_dirty;
  logic              hit_upd, fill, fl_clean, touch_en;
  logic [IDX-1:0]    touch_set;
  logic [WIW-1:0]    touch_way;
  logic              unused_addr;

  assign idx         = address_i[OFF+IDX-1:OFF];
  assign tag         = address_i[ADDR_W-1:OFF+IDX];
  assign wsel        = address_i[OFF-1:2];
  assign unused_addr = ^address_i[1:0];
  assign access      = MemRead_i | MemWrite_i;
  assign idle        = (state_q == S_IDLE);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WIW'(w);
      end
    end
  end

  always_comb begin
    vic_way   = '0;
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[idx][w]) begin
        vic_way   = WIW'(w);
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[idx][w] == WIW'(WAYS - 1)) vic_way = WIW'(w);
      end
    end
  end

  assign hit_line   = data_q[idx][hit_way];
  assign scan_set   = IDX'(32'(scan_q) / WAYS);
  assign scan_way   = WIW'(32'(scan_q) % WAYS);
  assign scan_last  = (scan_q == CW'(SETS * WAYS - 1));
  assign scan_dirty = valid_q[scan_set][scan_way] & dirty_q[scan_set][scan_way];

  assign hit_upd   = idle && access && hit;
  assign fill      = (state_q == S_REFILL) && mem_ack_i;
  assign fl_clean  = (state_q == S_FL_WB) && mem_ack_i;
  assign touch_en  = hit_upd | fill;
  assign touch_set = fill ? lat_idx_q : idx;
  assign touch_way = fill ? vic_q : hit_way;

  // Reset gating keeps the pipeline-facing outputs quiet while rst_i is low.
  assign read_data_o  = (rst_i && idle && MemRead_i && !MemWrite_i && hit)
                        ? hit_line[{wsel, 5'd0} +: 32] : 32'd0;
  assign mem_stall_o  = rst_i && (!idle || (access && !hit) || (!access && flush_i));
  assign flush_done_o = done_q;
  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_comb begin
    state_d    = state_q;
    lat_idx_d  = lat_idx_q;
    lat_tag_d  = lat_tag_q;
    vic_d      = vic_q;
    scan_d     = scan_q;
    mem_en_d   = mem_en_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !hit) begin
          lat_idx_d = idx;
          lat_tag_d = tag;
          vic_d     = vic_way;
          mem_en_d  = 1'b1;
          if (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) begin
            state_d    = S_WB;
            mem_we_d   = 1'b1;
            mem_addr_d = {tag_q[idx][vic_way], idx, {OFF{1'b0}}};
            mem_data_d = data_q[idx][vic_way];
          end else begin
            state_d    = S_REFILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, idx, {OFF{1'b0}}};
          end
        end else if (!access && flush_i) begin
          state_d = S_FL_SCAN;
          scan_d  = '0;
        end
      end
      S_WB: begin
        // Enable stays high: the refill read follows the write-back back to back.
        if (mem_ack_i) begin
          state_d    = S_REFILL;
          mem_we_d   = 1'b0;
          mem_addr_d = {lat_tag_q, lat_idx_q, {OFF{1'b0}}};
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          state_d  = S_DONE;
          mem_en_d = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_FL_SCAN: begin
        if (scan_dirty) begin
          state_d    = S_FL_WB;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = {tag_q[scan_set][scan_way], scan_set, {OFF{1'b0}}};
          mem_data_d = data_q[scan_set][scan_way];
        end else if (scan_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      S_FL_WB: begin
        if (mem_ack_i) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (scan_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FL_SCAN;
            scan_d  = scan_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      lat_idx_q  <= '0;
      lat_tag_q  <= '0;
      vic_q      <= '0;
      scan_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WIW'(w);
      end
    end else begin
      state_q    <= state_d;
      lat_idx_q  <= lat_idx_d;
      lat_tag_q  <= lat_tag_d;
      vic_q      <= vic_d;
      scan_q     <= scan_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
      if (hit_upd && MemWrite_i) dirty_q[idx][hit_way] <= 1'b1;
      if (fill) begin
        valid_q[lat_idx_q][vic_q] <= 1'b1;
        dirty_q[lat_idx_q][vic_q] <= 1'b0;
      end
      if (fl_clean) dirty_q[scan_set][scan_way] <= 1'b0;
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WIW'(w) == touch_way)
            age_q[touch_set][w] <= '0;
          else if (age_q[touch_set][w] < age_q[touch_set][touch_way])
            age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[lat_idx_q][vic_q] <= mem_data_i;
      tag_q[lat_idx_q][vic_q]  <= lat_tag_q;
    end else if (hit_upd && MemWrite_i) begin
      data_q[idx][hit_way][{wsel, 5'd0} +: 32] <= write_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_assoc_wb.sv
// tb/tb_dcache_assoc_wb.sv - directed bench for dcache_assoc_wb with a line-wide memory responder
module tb_dcache_assoc_wb;
  localparam int LINE_W = 256;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       address = '0;
  logic [31:0]       wdata = '0;
  logic              rd = 1'b0, wr = 1'b0, flush = 1'b0;
  logic [31:0]       read_data;
  logic              stall, flush_done;
  logic [LINE_W-1:0] mem_data_i = '0;
  logic              mem_ack = 1'b0;
  logic [LINE_W-1:0] mem_data_o;
  logic [31:0]       mem_addr;
  logic              mem_en, mem_we;

  dcache_assoc_wb dut (
    .clk_i(clk), .rst_i(rst_n), .address_i(address), .write_data_i(wdata),
    .MemRead_i(rd), .MemWrite_i(wr), .flush_i(flush), .read_data_o(read_data),
    .mem_stall_o(stall), .flush_done_o(flush_done), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack), .mem_data_o(mem_data_o), .mem_addr_o(mem_addr),
    .mem_enable_o(mem_en), .mem_write_o(mem_we)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] pat_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = {a[23:0], 8'(k)};
    if (a == 32'h40) l[31:0] = 32'hDEADBEEF;
    return l;
  endfunction

  // Memory responder: acks each transaction LAT cycles after it is seen; remembers written lines.
  logic [LINE_W-1:0] mem_model [int unsigned];
  logic [31:0]       log_addr [$];
  logic              log_we [$];
  logic [LINE_W-1:0] log_data [$];
  int  cnt = 0;
  bit  resp_en = 1'b1;
  bit  inj_tog = 1'b0, inj_seen = 1'b0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (inj_tog != inj_seen) begin
      inj_seen = inj_tog;
      mem_ack  = 1'b1;
    end else if (!rst_n || !resp_en || !mem_en) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt == LAT) begin
        cnt = 0;
        mem_ack = 1'b1;
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_data_o);
        if (mem_we) mem_model[mem_addr] = mem_data_o;
        else mem_data_i = mem_model.exists(mem_addr) ? mem_model[mem_addr] : pat_line(mem_addr);
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  task automatic access(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                        output int stalls, output logic [31:0] rdata);
    address = a; rd = r; wr = w; wdata = d; stalls = 0;
    @(negedge clk);
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) check("access_timeout", 32'(stalls), 32'd0);
    rdata = read_data;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic do_flush(output int stalls, output int dones);
    stalls = 0; dones = 0; flush = 1'b1;
    @(negedge clk);
    if (stall) stalls++;
    if (flush_done) dones++;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (stall) stalls++;
      if (flush_done) dones++;
    end
    @(posedge clk); #1;
  endtask

  int n, dn;
  logic [31:0] rv;
  logic [LINE_W-1:0] ln;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", 32'(mem_en), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(flush_done), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_data", 32'(|mem_data_o), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // flush with nothing dirty
    do_flush(n, dn);
    check("flush0_stall", 32'(n), 32'd33);
    check("flush0_done", 32'(dn), 32'd1);
    check("flush0_nwr", 32'(log_addr.size()), 32'd0);

    // cold miss then hit
    access(32'h040, 1, 0, 0, n, rv);
    check("miss_stall", 32'(n), 32'd4);
    check("miss_data", rv, 32'hDEADBEEF);
    check("miss_nlog", 32'(log_addr.size()), 32'd1);
    check("miss_addr", log_addr[0], 32'h040);
    check("miss_we", 32'(log_we[0]), 32'd0);
    access(32'h040, 1, 0, 0, n, rv);
    check("hit_stall", 32'(n), 32'd0);
    check("hit_data", rv, 32'hDEADBEEF);

    // dirty eviction
    clear_log();
    access(32'h044, 0, 1, 32'h1234, n, rv);
    check("wr_hit_stall", 32'(n), 32'd0);
    access(32'h240, 1, 0, 0, n, rv);
    check("fill_w1_stall", 32'(n), 32'd4);
    access(32'h440, 1, 0, 0, n, rv);
    check("evict_stall", 32'(n), 32'd6);
    check("evict_data", rv, 32'h00044000);
    check("evict_nlog", 32'(log_addr.size()), 32'd3);
    check("evict_wb_addr", log_addr[1], 32'h040);
    check("evict_wb_we", 32'(log_we[1]), 32'd1);
    ln = log_data[1];
    check("evict_wb_w0", ln[31:0], 32'hDEADBEEF);
    check("evict_wb_w1", ln[63:32], 32'h1234);
    check("evict_rd_addr", log_addr[2], 32'h440);
    check("evict_rd_we", 32'(log_we[2]), 32'd0);

    // LRU follows hits
    access(32'h040, 1, 0, 0, n, rv);
    check("lru_a_stall", 32'(n), 32'd4);
    access(32'h240, 1, 0, 0, n, rv);
    check("lru_b_stall", 32'(n), 32'd4);
    access(32'h040, 1, 0, 0, n, rv);
    check("lru_hit_stall", 32'(n), 32'd0);
    check("lru_hit_data", rv, 32'hDEADBEEF);
    access(32'h044, 1, 0, 0, n, rv);
    check("wb_roundtrip", rv, 32'h1234);
    clear_log();
    access(32'h640, 1, 0, 0, n, rv);
    check("lru_vic_stall", 32'(n), 32'd4);
    check("lru_vic_nlog", 32'(log_addr.size()), 32'd1);
    check("lru_vic_addr", log_addr[0], 32'h640);
    access(32'h040, 1, 0, 0, n, rv);
    check("lru_keep_stall", 32'(n), 32'd0);
    access(32'h240, 1, 0, 0, n, rv);
    check("lru_gone_stall", 32'(n), 32'd4);

    // flush writes back exactly the dirty lines
    access(32'h080, 0, 1, 32'hAAAA0001, n, rv);
    check("st080_stall", 32'(n), 32'd4);
    access(32'h2A0, 0, 1, 32'hBBBB0002, n, rv);
    check("st2a0_stall", 32'(n), 32'd4);
    clear_log();
    do_flush(n, dn);
    check("flush_stall", 32'(n), 32'd37);
    check("flush_done", 32'(dn), 32'd1);
    check("flush_nwr", 32'(log_addr.size()), 32'd2);
    check("flush_a0", log_addr[0], 32'h080);
    check("flush_we0", 32'(log_we[0]), 32'd1);
    ln = log_data[0];
    check("flush_d0", ln[31:0], 32'hAAAA0001);
    check("flush_a1", log_addr[1], 32'h2A0);
    ln = log_data[1];
    check("flush_d1", ln[31:0], 32'hBBBB0002);
    access(32'h080, 1, 0, 0, n, rv);
    check("post_flush_stall", 32'(n), 32'd0);
    check("post_flush_data", rv, 32'hAAAA0001);
    clear_log();
    do_flush(n, dn);
    check("reflush_stall", 32'(n), 32'd33);
    check("reflush_nwr", 32'(log_addr.size()), 32'd0);

    // read+write together is a write
    access(32'h040, 1, 1, 32'hA5A5A5A5, n, rv);
    check("rw_stall", 32'(n), 32'd0);
    access(32'h040, 1, 0, 0, n, rv);
    check("rw_data", rv, 32'hA5A5A5A5);

    // reset while waiting in WB
    access(32'h240, 0, 1, 32'h5, n, rv);
    check("dirty240_stall", 32'(n), 32'd0);
    clear_log();
    resp_en = 1'b0;
    address = 32'h440; rd = 1'b1;
    @(negedge clk);
    check("wbr_stall", 32'(stall), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("wbr_en", 32'(mem_en), 32'd1);
    check("wbr_we", 32'(mem_we), 32'd1);
    check("wbr_addr", mem_addr, 32'h040);
    check("wbr_w0", mem_data_o[31:0], 32'hA5A5A5A5);
    #2 rst_n = 1'b0;
    #1;
    check("async_en", 32'(mem_en), 32'd0);
    check("async_we", 32'(mem_we), 32'd0);
    check("async_addr", mem_addr, 32'd0);
    check("async_data", 32'(|mem_data_o), 32'd0);
    check("async_stall", 32'(stall), 32'd0);
    check("async_rdata", read_data, 32'd0);
    rd = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    resp_en = 1'b1;
    @(posedge clk); #1;
    inj_tog = ~inj_tog;
    repeat (2) @(posedge clk);
    #1;
    check("late_ack_en", 32'(mem_en), 32'd0);
    check("late_ack_stall", 32'(stall), 32'd0);
    access(32'h040, 1, 0, 0, n, rv);
    check("post_rst_stall", 32'(n), 32'd4);
    check("post_rst_nlog", 32'(log_addr.size()), 32'd1);
    check("post_rst_addr", log_addr[0], 32'h040);
    check("post_rst_data", rv, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
